decode_pipe: RTL
================

Name: decode_pipe

Overview:
- Parametrised next-generation DECODE stage for the pipelined LEGv8 core.
- Contains the register file with a write-through bypass, register-2 address selection, and sign extension via the existing signext unit.
- Adds an integrated load-use hazard detector and the ID/EX pipeline register with bubble and flush control.
- Sits between the IF/ID register and EXECUTE. Writeback drives it through the write port.

Parameters:
- N, 64, datapath width of register data and the extended immediate.
- NREG, 32, number of architectural registers (power of 2, ≥4). Index NREG-1 is the zero register XZR.
- AW, $clog2(NREG), register address width (derived; do not override).

Ports:
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  synchronous, active-high.
- instr_D  in  32  instruction from IF/ID.
- valid_D  in  1  instr_D holds a real instruction.
- reg2loc_D  in  1  0: ra2=instr_D[20:16]; 1: ra2=instr_D[4:0].
- regWrite_D  in  1  decoded write-enable of instr_D.
- memRead_D  in  1  instr_D is a load.
- flush_E  in  1  branch taken in EXECUTE; kill the instruction entering EX.
- regWrite_W  in  1  writeback write enable.
- wa3_W  in  AW  writeback destination.
- writeData3_W  in  N  writeback data.
- stall_D  out  1  combinational; hold PC and IF/ID this cycle.
- readData1_E, readData2_E  out  N  registered operands.
- signImm_E  out  N  registered extended immediate.
- ra1_E, ra2_E, wa_E  out  AW  registered source and destination addresses, for forwarding. wa_E=instr[4:0].
- regWrite_E, memRead_E, valid_E  out  1  registered controls.

Behaviour:
- Address selection: ra1=instr_D[9:5]. ra2 is selected by reg2loc_D as listed under Ports. The 5-bit fields are truncated or zero-extended to AW.
- Register file:
  - Reads are combinational.
  - Writes happen on posedge when regWrite_W=1 and wa3_W≠NREG-1.
  - Reading NREG-1 always returns 0. Writes to NREG-1 are ignored.
- Hazard detection: hazard = valid_E & memRead_E & (wa_E≠NREG-1) & valid_D & ((wa_E==ra1) | (wa_E==ra2)).
- stall_D = hazard & ~flush_E.
- ID/EX register update on posedge, priority highest first:
  1. reset: all ID/EX outputs go to 0. All NREG registers are cleared to 0.
  2. flush_E: insert a bubble. valid_E, regWrite_E and memRead_E go to 0; data fields are don't-care and held at 0.
  3. hazard: insert a bubble, same as flush.
  4. Otherwise load from decode:
     - operands, signImm, ra1, ra2 and wa.
     - regWrite_E = regWrite_D & valid_D.
     - memRead_E = memRead_D & valid_D.
     - valid_E = valid_D.
- Latency: one cycle from instr_D to the _E outputs. A stall lasts exactly one cycle per load-use pair, because the load leaves EX next cycle.
- Simultaneous events:
  - A writeback and a reset in the same cycle: reset wins and the register stays 0.
  - flush_E together with hazard: the bubble is inserted and stall_D=0, because the IF/ID contents are dead.
- Reset mid-stall: stall_D is combinational and drops the cycle after reset because valid_E=0.
- Each output is registered independently; there is no implicit state machine. The ID/EX register has two logical states, LOAD and BUBBLE, selected each cycle by the priority list above.

Optional Feature:
- Macro: DECODE_BYPASS_EN.
- Defined: write-through bypass. If regWrite_W and wa3_W==raX and raX≠NREG-1, readDataX returns writeData3_W in the same cycle.
- Undefined: the read returns the pre-write register value. The hazard equation is unchanged in both builds.

Test Plan:
- Reset, then read X0..X31 with no writes. Required: all operands 0; valid_E=0, regWrite_E=0, memRead_E=0.
- Write X3=0x1234 in cycle k, then decode ADD X5,X3,X3 in cycle k+1. Required: readData1_E=readData2_E=0x1234. Write X31=0xFF, then read X31. Required: 0.
- Same-cycle write of X7=0xABCD while decoding a read of X7. With DECODE_BYPASS_EN: 0xABCD. Without it: the previous value (0 after reset).
- LDUR X9,[X1] in EX, then ADD X2,X9,X4 in D. Required: stall_D=1 for one cycle, then a bubble (valid_E=0), then the ADD enters EX. Repeat with destination X31. Required: no stall.
- Load-use hazard with flush_E=1 in the same cycle. Required: stall_D=0 and a bubble inserted. flush_E alone with a valid ADD in D. Required: valid_E=0 next cycle.
- STUR (reg2loc_D=1) with Rt=instr[4:0]=6 and X6=0x55. Required: ra2_E=6 and readData2_E=0x55. Sign-extension check: imm9=-8 gives signImm_E=0xFFFF_FFFF_FFFF_FFF8.

Source files
------------

// File: rtl/decode_pipe.sv
// decode_pipe: LEGv8 decode stage with register file, sign extension,
// load-use hazard detection and the ID/EX pipeline register.
// Optional feature macro: DECODE_BYPASS_EN (write-through register bypass).
//
// Handshake note: there is no valid/ready pair here. valid_D qualifies
// instr_D, stall_D asks IF to hold PC and IF/ID for one cycle, and
// valid_E qualifies everything presented to EXECUTE.
module decode_pipe #(
  parameter int N    = 64,
  parameter int NREG = 32,
  localparam int AW  = $clog2(NREG)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [31:0]   instr_D,
  input  logic          valid_D,
  input  logic          reg2loc_D,
  input  logic          regWrite_D,
  input  logic          memRead_D,
  input  logic          flush_E,
  input  logic          regWrite_W,
  input  logic [AW-1:0] wa3_W,
  input  logic [N-1:0]  writeData3_W,
  output logic          stall_D,
  output logic [N-1:0]  readData1_E,
  output logic [N-1:0]  readData2_E,
  output logic [N-1:0]  signImm_E,
  output logic [AW-1:0] ra1_E,
  output logic [AW-1:0] ra2_E,
  output logic [AW-1:0] wa_E,
  output logic          regWrite_E,
  output logic          memRead_E,
  output logic          valid_E
);

  localparam logic [AW-1:0] XZR = AW'(NREG - 1);

  // ID/EX contents; a bubble is the all-zero value.
  typedef struct packed {
    logic [N-1:0]  rd1;
    logic [N-1:0]  rd2;
    logic [N-1:0]  imm;
    logic [AW-1:0] ra1;
    logic [AW-1:0] ra2;
    logic [AW-1:0] wa;
    logic          reg_write;
    logic          mem_read;
    logic          valid;
  } idex_t;

  // Which of the two ID/EX update modes was chosen this cycle (debug visibility).
  typedef enum logic {IDEX_LOAD, IDEX_BUBBLE} idex_mode_e;

  logic [N-1:0]  rf_q [NREG];
  logic [N-1:0]  rf_d [NREG];
  logic [AW-1:0] ra1;
  logic [AW-1:0] ra2;
  logic [AW-1:0] wa;
  logic [N-1:0]  rd1;
  logic [N-1:0]  rd2;
  logic [N-1:0]  sign_imm;
  logic          hazard;
  idex_t         idex_d;
  idex_t         idex_q;
  idex_mode_e    idex_mode;

  // 5-bit instruction register fields are truncated or zero-extended to AW.
  function automatic logic [AW-1:0] fit_addr(input logic [4:0] f);
    return AW'({27'd0, f});
  endfunction

  // Immediate extraction: ADDI/SUBI zero-extend imm12, D-type sign-extends
  // imm9, B sign-extends imm26, CBZ/CBNZ sign-extend imm19, else 0.
  function automatic logic [N-1:0] sign_ext(input logic [31:0] i);
    logic [N-1:0] y;
    casez (i[31:21])
      11'b1?01000100?: y = N'(i[21:10]);
      11'b111110000?0: y = N'($signed(i[20:12]));
      11'b000101?????: y = N'($signed(i[25:0]));
      11'b1011010????: y = N'($signed(i[23:5]));
      default:         y = '0;
    endcase
    return y;
  endfunction

  // Decode-side address selection and immediate.
  always_comb begin
    ra1      = fit_addr(instr_D[9:5]);
    ra2      = reg2loc_D ? fit_addr(instr_D[4:0]) : fit_addr(instr_D[20:16]);
    wa       = fit_addr(instr_D[4:0]);
    sign_imm = sign_ext(instr_D);
  end

  // Register file next state: one write port, XZR is never written.
  always_comb begin
    for (int i = 0; i < NREG; i++) rf_d[i] = rf_q[i];
    if (regWrite_W && (wa3_W != XZR)) rf_d[wa3_W] = writeData3_W;
  end

  // Register file storage; reset clears every register and beats a writeback.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) rf_q[i] <= '0;
    end else begin
      for (int i = 0; i < NREG; i++) rf_q[i] <= rf_d[i];
    end
  end

  // Combinational reads; XZR reads as zero, optional same-cycle bypass.
  always_comb begin
    rd1 = (ra1 == XZR) ? '0 : rf_q[ra1];
    rd2 = (ra2 == XZR) ? '0 : rf_q[ra2];
`ifdef DECODE_BYPASS_EN
    if (regWrite_W && (wa3_W == ra1) && (ra1 != XZR)) rd1 = writeData3_W;
    if (regWrite_W && (wa3_W == ra2) && (ra2 != XZR)) rd2 = writeData3_W;
`endif
  end

  // Load-use hazard: a load in EX whose destination feeds the decoding instruction.
  always_comb begin
    hazard  = idex_q.valid & idex_q.mem_read & (idex_q.wa != XZR) & valid_D &
              ((idex_q.wa == ra1) | (idex_q.wa == ra2));
    stall_D = hazard & ~flush_E;
  end

  // ID/EX next state: bubble on flush or hazard, otherwise load from decode.
  always_comb begin
    idex_d    = '0;
    idex_mode = IDEX_BUBBLE;
    if (!(flush_E || hazard)) begin
      idex_mode        = IDEX_LOAD;
      idex_d.rd1       = rd1;
      idex_d.rd2       = rd2;
      idex_d.imm       = sign_imm;
      idex_d.ra1       = ra1;
      idex_d.ra2       = ra2;
      idex_d.wa        = wa;
      idex_d.reg_write = regWrite_D & valid_D;
      idex_d.mem_read  = memRead_D & valid_D;
      idex_d.valid     = valid_D;
    end
  end

  // ID/EX register.
  always_ff @(posedge clk) begin
    if (reset) idex_q <= '0;
    else       idex_q <= idex_d;
  end

  assign readData1_E = idex_q.rd1;
  assign readData2_E = idex_q.rd2;
  assign signImm_E   = idex_q.imm;
  assign ra1_E       = idex_q.ra1;
  assign ra2_E       = idex_q.ra2;
  assign wa_E        = idex_q.wa;
  assign regWrite_E  = idex_q.reg_write;
  assign memRead_E   = idex_q.mem_read;
  assign valid_E     = idex_q.valid;

endmodule
